// File: rtl/asm_array.sv
// asm_array: CHANNELS binary-weighted accumulators share one signed pixel stream; each adds a BN offset and emits a sign bit.
// Latency: result valid one edge after the window-closing beat; an N-beat window occupies N+2 cycles.
// Backpressure: result held in OUT until out_ready; in_ready low in SCORE/OUT. Define ASM_SATURATE_EN for clamping + ovf.
module asm_array #(
    parameter int IMG_WIDTH    = 16,
    parameter int BN_WIDTH     = 16,
    parameter int RESULT_WIDTH = 22,
    parameter int CHANNELS     = 8,
    parameter int MAX_TAPS     = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bn_valid,
    input  logic [BN_WIDTH-1:0]  data_bn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [IMG_WIDTH-1:0] data_pix,
    input  logic [CHANNELS-1:0]  data_weights,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHANNELS-1:0]  data_out,
    output logic                 ovf
);

    localparam int TAP_W = $clog2(MAX_TAPS + 1);
    localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic signed [RESULT_WIDTH:0] SCORE_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCORE = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [TAP_W-1:0]               tap_cnt;
    logic [PTR_W-1:0]               bn_ptr;
    logic signed [BN_WIDTH-1:0]     bn_reg  [CHANNELS];
    logic signed [RESULT_WIDTH-1:0] acc     [CHANNELS];
    logic signed [RESULT_WIDTH-1:0] acc_nxt [CHANNELS];
    logic [CHANNELS-1:0]            score_bit;

    logic beat_acc;
    logic win_close;
    logic bn_wr;
    logic out_take;

    assign beat_acc  = in_valid & in_ready;
    assign win_close = beat_acc & (in_last | (tap_cnt == TAP_W'(MAX_TAPS - 1)));
    assign bn_wr     = bn_valid & (state == IDLE);
    assign out_take  = (state == OUT) & out_ready;
    assign out_valid = (state == OUT);

`ifdef ASM_SATURATE_EN
    // One extra bit holds the unclamped sum; top two bits differing means the RESULT_WIDTH range was left.
    logic signed [RESULT_WIDTH:0] pix_wide;
    logic signed [RESULT_WIDTH:0] acc_sum [CHANNELS];
    logic [CHANNELS-1:0]          sat_hit;

    assign pix_wide = (RESULT_WIDTH + 1)'($signed(data_pix));

    always_comb begin
        sat_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            acc_sum[i] = (RESULT_WIDTH + 1)'(acc[i]) + (data_weights[i] ? pix_wide : -pix_wide);
            acc_nxt[i] = acc_sum[i][RESULT_WIDTH-1:0];
            if (acc_sum[i][RESULT_WIDTH] != acc_sum[i][RESULT_WIDTH-1]) begin
                sat_hit[i] = 1'b1;
                acc_nxt[i] = acc_sum[i][RESULT_WIDTH] ? {1'b1, {(RESULT_WIDTH-1){1'b0}}}
                                                      : {1'b0, {(RESULT_WIDTH-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (out_take) begin
            ovf <= 1'b0;
        end else if (beat_acc && (|sat_hit)) begin
            ovf <= 1'b1;
        end
    end
`else
    logic signed [RESULT_WIDTH-1:0] pix_ext;

    assign pix_ext = RESULT_WIDTH'($signed(data_pix));

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            acc_nxt[i] = acc[i] + (data_weights[i] ? pix_ext : -pix_ext);
        end
    end

    assign ovf = 1'b0;
`endif

    // Score at RESULT_WIDTH+1 bits so acc + offset can never wrap.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            score_bit[i] = ((RESULT_WIDTH + 1)'(acc[i]) + (RESULT_WIDTH + 1)'(bn_reg[i])) >= SCORE_ZERO;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (beat_acc) begin
                    state_nxt = win_close ? SCORE : ACCUM;
                end
            end
            SCORE:   state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready is registered so it stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            tap_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == IDLE) || (state_nxt == ACCUM);
            if (out_take) begin
                tap_cnt <= '0;
            end else if (beat_acc) begin
                tap_cnt <= tap_cnt + TAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
        end else if (out_take) begin
            for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
        end else if (beat_acc) begin
            for (int i = 0; i < CHANNELS; i++) acc[i] <= acc_nxt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bn_ptr <= '0;
            for (int i = 0; i < CHANNELS; i++) bn_reg[i] <= '0;
        end else if (bn_wr) begin
            bn_reg[bn_ptr] <= $signed(data_bn);
            bn_ptr         <= (bn_ptr == PTR_W'(CHANNELS - 1)) ? '0 : bn_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (state == SCORE) begin
            data_out <= score_bit;
        end
    end

endmodule

// File: tb/tb_asm_array.sv
// Scoreboard bench for asm_array with 4 channels; a second instance with an 8-tap limit covers the forced close.
module tb_asm_array;

    localparam int IW = 16;
    localparam int BW = 16;
    localparam int RW = 22;
    localparam int CH = 4;
    localparam longint AMAX = (longint'(1) << (RW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) << (RW - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic          bn_valid;
    logic [BW-1:0] data_bn;
    logic          in_valid;
    logic          in_last;
    logic [IW-1:0] data_pix;
    logic [CH-1:0] data_weights;
    logic          out_ready;
    logic          sel;

    logic          in_ready_a, out_valid_a, ovf_a;
    logic [CH-1:0] data_out_a;
    logic          in_ready_b, out_valid_b, ovf_b;
    logic [CH-1:0] data_out_b;

    logic          in_ready, out_valid, ovf;
    logic [CH-1:0] data_out;

    assign in_ready  = sel ? in_ready_b  : in_ready_a;
    assign out_valid = sel ? out_valid_b : out_valid_a;
    assign ovf       = sel ? ovf_b       : ovf_a;
    assign data_out  = sel ? data_out_b  : data_out_a;

    asm_array #(.IMG_WIDTH(IW), .BN_WIDTH(BW), .RESULT_WIDTH(RW), .CHANNELS(CH), .MAX_TAPS(256)) dut_a (
        .clk(clk), .rst(rst), .bn_valid(bn_valid), .data_bn(data_bn),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_last(in_last),
        .data_pix(data_pix), .data_weights(data_weights),
        .out_valid(out_valid_a), .out_ready(out_ready), .data_out(data_out_a), .ovf(ovf_a)
    );

    asm_array #(.IMG_WIDTH(IW), .BN_WIDTH(BW), .RESULT_WIDTH(RW), .CHANNELS(CH), .MAX_TAPS(8)) dut_b (
        .clk(clk), .rst(rst), .bn_valid(bn_valid), .data_bn(data_bn),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_last(in_last),
        .data_pix(data_pix), .data_weights(data_weights),
        .out_valid(out_valid_b), .out_ready(out_ready), .data_out(data_out_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0] dout;
        logic          ovf;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;
    longint m_acc[CH];
    longint m_win_acc[CH];
    longint m_bn[CH];
    int     m_ptr;
    int     m_taps;
    logic   m_ovf;
    int     checks   = 0;
    int     failures = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap_rw(input longint v);
        longint r;
        r = v & ((longint'(1) << RW) - 1);
        if (r > AMAX) r = r - (longint'(1) << RW);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_acc[i] = 0;
            m_bn[i]  = 0;
        end
        m_ptr  = 0;
        m_taps = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_beat(input longint pix, input logic [CH-1:0] w, input logic last);
        exp_t e;
        for (int i = 0; i < CH; i++) begin
            m_acc[i] = m_acc[i] + (w[i] ? pix : -pix);
`ifdef ASM_SATURATE_EN
            if (m_acc[i] > AMAX) begin m_acc[i] = AMAX; m_ovf = 1'b1; end
            if (m_acc[i] < AMIN) begin m_acc[i] = AMIN; m_ovf = 1'b1; end
`else
            m_acc[i] = wrap_rw(m_acc[i]);
`endif
        end
        m_taps++;
        if (last || m_taps == (sel ? 8 : 256)) begin
            for (int i = 0; i < CH; i++) begin
                e.dout[i]    = (m_acc[i] + m_bn[i]) >= 0;
                m_win_acc[i] = m_acc[i];
                m_acc[i]     = 0;
            end
            e.ovf = m_ovf;
            sb_q.push_back(e);
            m_taps = 0;
            m_ovf  = 1'b0;
        end
    endtask

    task automatic send_beat(input logic signed [IW-1:0] pix, input logic [CH-1:0] w,
                             input logic last, output int waited);
        in_valid = 1'b1; data_pix = pix; data_weights = w; in_last = last;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            chk("beat_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        model_beat(longint'(pix), w, last);
    endtask

    task automatic load_bn(input logic signed [BW-1:0] val);
        bn_valid = 1'b1; data_bn = val;
        @(posedge clk); #1;
        bn_valid = 1'b0;
        m_bn[m_ptr] = longint'(val);
        m_ptr = (m_ptr + 1) % CH;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && in_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(sb_q.size() == 0 && in_ready)) chk("idle_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_ovf", ovf, 0);
        model_reset();
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_in_ready", in_ready, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("data_out", data_out, mon_e.dout);
                chk("ovf", ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        int wt;
        sel = 1'b0; rst = 1'b1; bn_valid = 1'b0; data_bn = '0; in_valid = 1'b0;
        in_last = 1'b0; data_pix = '0; data_weights = '0; out_ready = 1'b1;
        model_reset();
        pulse_reset();

        // 1: basic window with per-channel offsets
        load_bn(0); load_bn(-5); load_bn(10); load_bn(-100);
        send_beat(3, 4'b1111, 1'b0, wt);
        send_beat(3, 4'b1111, 1'b0, wt);
        send_beat(3, 4'b1111, 1'b1, wt);
        for (int i = 0; i < CH; i++) chk("t1_acc", dut_a.acc[i], 9);
        chk("t1_lat_score", out_valid, 0);
        @(posedge clk); #1;
        chk("t1_lat_out", out_valid, 1);
        chk("t1_dout", data_out, 4'b0111);
        wait_idle();

        // 2: mixed weights, then a zero score
        load_bn(0); load_bn(0); load_bn(0); load_bn(0);
        send_beat(7, 4'b0101, 1'b1, wt);
        wait_idle();
        send_beat(0, 4'b0011, 1'b1, wt);
        @(posedge clk); #1;
        chk("t2_zero_dout", data_out, 4'b1111);
        wait_idle();

        // 3: long positive run past the accumulator range
        for (int b = 0; b < 65; b++) send_beat(32767, 4'b1111, b == 64, wt);
        @(posedge clk); #1;
        chk("t3_out_valid", out_valid, 1);
`ifdef ASM_SATURATE_EN
        chk("t3_acc", dut_a.acc[0], 2097151);
        chk("t3_ovf", ovf, 1);
        chk("t3_dout", data_out, 4'b1111);
`else
        chk("t3_acc", dut_a.acc[0], -2064449);
        chk("t3_ovf", ovf, 0);
        chk("t3_dout", data_out, 4'b0000);
`endif
        wait_idle();

        // 4: consumer stalls; offered beats and offsets must be ignored
        out_ready = 1'b0;
        send_beat(-5, 4'b0011, 1'b1, wt);
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; data_pix = 16'd1000; data_weights = 4'b1111; in_last = 1'b1;
            bn_valid = 1'b1; data_bn = 16'd999;
            @(posedge clk); #1;
            chk("t4_out_valid", out_valid, 1);
            chk("t4_dout_hold", data_out, sb_q.size() > 0 ? sb_q[0].dout : 4'bxxxx);
            chk("t4_in_ready", in_ready, 0);
        end
        in_valid = 1'b0; in_last = 1'b0; bn_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        send_beat(2, 4'b1010, 1'b1, wt);
        wait_idle();

        // 6: reset in the middle of a window
        send_beat(100, 4'b1111, 1'b0, wt);
        send_beat(100, 4'b1111, 1'b0, wt);
        pulse_reset();
        for (int i = 0; i < CH; i++) chk("t6_bn_cleared", dut_a.bn_reg[i], 0);
        send_beat(-1, 4'b0000, 1'b1, wt);
        @(posedge clk); #1;
        chk("t6_dout", data_out, 4'b1111);
        wait_idle();

        // 5: forced close at the 8-tap limit
        sel = 1'b1;
        pulse_reset();
        for (int b = 0; b < 8; b++) send_beat(1, 4'b1111, 1'b0, wt);
        chk("t5_closed", in_ready, 0);
        chk("t5_queued", sb_q.size(), 1);
        send_beat(1, 4'b1111, 1'b1, wt);
        chk("t5_beat9_wait", wt, 2);
        wait_idle();

        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
